// File: rtl/ready_sync_n.sv
// ready_sync_n: N-player ready synchroniser and start-number generator.
// Players latch ready requests. Once every enabled player is ready, the block
// fires a one-cycle OK pulse with a pseudo-random start number in 1..NUM_MAX.
// That number is held until the game FSM reaches a round-clearing state.
// A tick-based timeout abandons partial ready sets.
module ready_sync_n #(
  parameter int          N_PLAYERS     = 2,
  parameter int          NUM_W         = 4,
  parameter int          NUM_MAX       = 10,
  parameter int          TICK_DIV      = 5000000,
  parameter int          TIMEOUT_TICKS = 10,
  parameter logic [15:0] CLEAR_MASK    = 16'h0F40
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [N_PLAYERS-1:0]               READY,
  input  logic [N_PLAYERS-1:0]               ENABLE_MASK,
  input  logic [3:0]                         STATE,
  output logic [NUM_W-1:0]                   NUM,
  output logic                               OK,
  output logic [N_PLAYERS-1:0]               LED,
  output logic [$clog2(N_PLAYERS+1)-1:0]     READY_CNT,
  output logic                               TIMEOUT,
  output logic                               BUSY
);

  localparam int CNT_W   = $clog2(N_PLAYERS + 1);
  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int TO_W    = (TIMEOUT_TICKS < 1) ? 1 : $clog2(TIMEOUT_TICKS + 1);
  localparam int TO_LAST = (TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FIRE, S_HOLD} state_t;

  state_t                 state, state_next;
  logic [N_PLAYERS-1:0]   keep, keep_next;
  logic [TICK_W-1:0]      tick_cnt;
  logic [NUM_W-1:0]       roll;
  logic [TO_W-1:0]        to_cnt;
  logic [N_PLAYERS-1:0]   led_p1;
  logic [CNT_W-1:0]       ready_cnt_p1;
  logic                   clr, tick, all_rdy, timeout_hit;

  // Number of latched players.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_PLAYERS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_PLAYERS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Next roll value, wrapping from NUM_MAX-1 back to 0.
  function automatic logic [NUM_W-1:0] roll_inc(input logic [NUM_W-1:0] r);
    return (r == NUM_W'(NUM_MAX - 1)) ? '0 : r + NUM_W'(1);
  endfunction

  assign clr     = CLEAR_MASK[STATE];
  assign tick    = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign all_rdy = (ENABLE_MASK != '0) && ((keep & ENABLE_MASK) == ENABLE_MASK);
  // Round clear outranks the timeout, so no TIMEOUT pulse on a clearing cycle.
  assign timeout_hit = (TIMEOUT_TICKS != 0) && (state == S_COLLECT) && tick &&
                       (to_cnt == TO_W'(TO_LAST)) && !clr;

  assign BUSY      = (state == S_FIRE) || (state == S_HOLD);
  assign LED       = led_p1;
  assign READY_CNT = ready_cnt_p1;

  // Next-state and next ready set: clear beats timeout beats fire beats set.
  always_comb begin
    state_next = state;
    keep_next  = keep & ENABLE_MASK;
    if (state == S_IDLE || state == S_COLLECT) keep_next = keep_next | (READY & ENABLE_MASK);
    case (state)
      S_IDLE:    if (keep != '0) state_next = S_COLLECT;
      S_COLLECT: if (all_rdy) state_next = S_FIRE;
      S_FIRE:    state_next = S_HOLD;
      S_HOLD:    state_next = S_HOLD;
      default:   state_next = S_IDLE;
    endcase
    if (clr) begin
      keep_next  = '0;
      state_next = (state == S_FIRE) ? S_HOLD : S_IDLE;
    end else if (timeout_hit) begin
      keep_next  = '0;
      state_next = S_IDLE;
    end
  end

  // State register and latched ready set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      keep  <= '0;
    end else begin
      state <= state_next;
      keep  <= keep_next;
    end
  end

  // Free-running tick divider and the roll it advances (frozen while busy).
  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt <= '0;
      roll     <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      if (tick && state != S_FIRE && state != S_HOLD) roll <= roll_inc(roll);
    end
  end

  // Ticks spent in COLLECT; restarts whenever the FSM is elsewhere.
  always_ff @(posedge CLK) begin
    if (RST)                    to_cnt <= '0;
    else if (state != S_COLLECT) to_cnt <= '0;
    else if (tick)              to_cnt <= to_cnt + TO_W'(1);
  end

  // Start number, start pulse and timeout pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      NUM     <= '0;
      OK      <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      OK      <= (state_next == S_FIRE);
      TIMEOUT <= timeout_hit;
      if (state_next == S_FIRE)                         NUM <= roll + NUM_W'(1);
      else if (state == S_HOLD && state_next == S_IDLE) NUM <= '0;
    end
  end

  // Indicator stage: LED and count trail the latched set by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      led_p1       <= '0;
      ready_cnt_p1 <= '0;
    end else begin
      led_p1       <= keep;
      ready_cnt_p1 <= popcount(keep);
    end
  end

endmodule

// File: tb/tb_ready_sync_n.sv
// Testbench for ready_sync_n: directed scenarios with hand-computed values,
// then randomized traffic, all compared against a behavioural model.
module tb_ready_sync_n;
  localparam int N        = 3;
  localparam int NUM_W    = 4;
  localparam int NUM_MAX  = 10;
  localparam int TICK_DIV = 4;
  localparam int TO_TICKS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ready = 3'b000;
  logic [2:0] mask = 3'b111;
  logic [3:0] gstate = 4'd0;
  logic [3:0] num;
  logic       ok;
  logic [2:0] led;
  logic [1:0] cnt;
  logic       tmo;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ready_sync_n #(
    .N_PLAYERS(N), .NUM_W(NUM_W), .NUM_MAX(NUM_MAX), .TICK_DIV(TICK_DIV),
    .TIMEOUT_TICKS(TO_TICKS), .CLEAR_MASK(16'h0F40)
  ) dut (
    .CLK(clk), .RST(rst), .READY(ready), .ENABLE_MASK(mask), .STATE(gstate),
    .NUM(num), .OK(ok), .LED(led), .READY_CNT(cnt), .TIMEOUT(tmo), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_COLLECT, M_FIRE, M_HOLD} phase_t;
  phase_t     m_phase = M_IDLE;
  logic [2:0] m_keep = 3'b000;
  logic [2:0] m_led = 3'b000;
  int m_cnt = 0, m_num = 0, m_ok = 0, m_to = 0, m_roll = 0, m_tcnt = 0, m_toc = 0;

  // Round-clearing game states: DRAW, GOOD, OUCH, WIN, LOSE.
  function automatic bit is_round_clear(input logic [3:0] s);
    return (s == 4'd6) || (s >= 4'd8 && s <= 4'd11);
  endfunction

  task automatic model_step();
    phase_t     old;
    bit         clr, tick, all, tout;
    logic [2:0] en, k_old;
    if (rst) begin
      m_phase = M_IDLE; m_keep = 3'b000; m_led = 3'b000;
      m_cnt = 0; m_num = 0; m_ok = 0; m_to = 0; m_roll = 0; m_tcnt = 0; m_toc = 0;
      return;
    end
    old   = m_phase;
    k_old = m_keep;
    en    = mask;
    clr   = is_round_clear(gstate);
    tick  = (m_tcnt == TICK_DIV - 1);
    all   = (en != 3'b000) && ((k_old & en) == en);
    tout  = (old == M_COLLECT) && tick && (m_toc + 1 == TO_TICKS) && !clr;
    m_led = k_old;
    m_cnt = $countones(k_old);
    m_to  = int'(tout);
    if (clr) begin
      m_keep  = 3'b000;
      m_phase = (old == M_FIRE) ? M_HOLD : M_IDLE;
      if (old == M_HOLD) m_num = 0;
    end else if (tout) begin
      m_keep  = 3'b000;
      m_phase = M_IDLE;
    end else begin
      m_keep = k_old & en;
      if (old == M_IDLE || old == M_COLLECT) m_keep = m_keep | (ready & en);
      if (old == M_IDLE && k_old != 3'b000) m_phase = M_COLLECT;
      else if (old == M_COLLECT && all) begin
        m_phase = M_FIRE;
        m_num   = m_roll + 1;
      end else if (old == M_FIRE) m_phase = M_HOLD;
    end
    if (tick && old != M_FIRE && old != M_HOLD) m_roll = (m_roll + 1) % NUM_MAX;
    m_tcnt = (m_tcnt + 1) % TICK_DIV;
    m_toc  = (old == M_COLLECT) ? m_toc + int'(tick) : 0;
    m_ok   = int'(m_phase == M_FIRE);
  endtask

  // Advance the model on each edge, compare just after it.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("NUM", num, m_num);
      check("OK", ok, m_ok);
      check("LED", led, m_led);
      check("READY_CNT", cnt, m_cnt);
      check("TIMEOUT", tmo, m_to);
      check("BUSY", busy, int'(m_phase == M_FIRE || m_phase == M_HOLD));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ready(input logic [2:0] r);
    ready = r;
    step(1);
    ready = 3'b000;
  endtask

  task automatic fire_round();
    bit seen;
    seen = 1'b0;
    pulse_ready(3'b111);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (ok) seen = 1'b1;
      else step(1);
    end
    check("fire_ok_seen", seen, 1);
    step(1);
  endtask

  task automatic clear_round(input logic [3:0] s);
    gstate = s;
    step(1);
    check("clr_num", num, 0);
    check("clr_busy", busy, 0);
    gstate = 4'd0;
    step(1);
    check("clr_led", led, 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int tpulses, okc;
    logic [3:0] clr_codes [4];
    clr_codes[0] = 4'd6; clr_codes[1] = 4'd8; clr_codes[2] = 4'd10; clr_codes[3] = 4'd11;

    step(1);
    check("rst_num", num, 0);
    check("rst_ok", ok, 0);
    check("rst_led", led, 0);
    check("rst_cnt", cnt, 0);
    check("rst_busy", busy, 0);
    step(1);
    rst = 1'b0;

    // Roll reaches 9 after 36 edges: fire at edge 38 gives NUM=10.
    step(35);
    ready = 3'b111;
    step(1);
    ready = 3'b000;
    step(2);
    check("wrap_ok", ok, 1);
    check("wrap_num10", num, 10);
    step(1);
    gstate = 4'd6;
    step(1);
    check("wrap_clr_num", num, 0);
    gstate = 4'd0;
    // Roll was frozen on the HOLD tick; it wraps to 0 at edge 44.
    step(3);
    ready = 3'b111;
    step(1);
    ready = 3'b000;
    step(2);
    check("wrap_num1", num, 1);
    step(1);
    gstate = 4'd9;
    step(1);
    gstate = 4'd0;
    check("clr9_num", num, 0);

    // Staggered ready 001, 100, 010.
    step(2);
    ready = 3'b001;
    step(1);
    ready = 3'b100;
    step(1);
    ready = 3'b010;
    check("seq_led1", led, 3'b001);
    check("seq_cnt1", cnt, 1);
    step(1);
    ready = 3'b000;
    check("seq_led2", led, 3'b101);
    check("seq_cnt2", cnt, 2);
    check("seq_ok_early", ok, 0);
    step(1);
    check("seq_led3", led, 3'b111);
    check("seq_cnt3", cnt, 3);
    check("seq_ok", ok, 1);
    check("seq_num", num, 2);
    step(1);
    check("seq_ok_drop", ok, 0);
    ready = 3'b111;
    step(1);
    ready = 3'b010;
    step(1);
    ready = 3'b000;
    step(1);
    check("hold_num", num, 2);
    check("hold_busy", busy, 1);
    check("hold_led", led, 3'b111);
    clear_round(4'd9);

    for (int i = 0; i < 4; i++) begin
      fire_round();
      clear_round(clr_codes[i]);
    end

    fire_round();
    gstate = 4'd5;
    step(2);
    check("state5_busy", busy, 1);
    check("state5_num_nz", int'(num != 4'd0), 1);
    clear_round(4'd6);

    // Partial set times out.
    pulse_ready(3'b011);
    tpulses = 0;
    okc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tmo) tpulses++;
      if (ok) okc++;
    end
    check("to_pulses", tpulses, 1);
    check("to_no_ok", okc, 0);
    check("to_led", led, 0);
    check("to_num", num, 0);

    // Mask reduced mid-collection fires on the next edge.
    pulse_ready(3'b011);
    step(1);
    mask = 3'b011;
    step(1);
    check("mask_ok", ok, 1);
    step(1);
    clear_round(4'd6);
    ready = 3'b100;
    step(1);
    ready = 3'b000;
    step(2);
    check("dis_led", led, 0);
    check("dis_busy", busy, 0);
    mask = 3'b111;

    // Ready coinciding with a clearing state is dropped.
    gstate = 4'd6;
    ready = 3'b111;
    step(1);
    gstate = 4'd0;
    ready = 3'b000;
    step(2);
    check("clrrdy_led", led, 0);
    check("clrrdy_cnt", cnt, 0);

    // Reset during HOLD.
    fire_round();
    rst = 1'b1;
    step(1);
    check("rsthold_num", num, 0);
    check("rsthold_busy", busy, 0);
    rst = 1'b0;
    step(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 29) == 0) gstate = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) gstate = 4'd0;
      if ($urandom_range(0, 99) == 0) mask = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 199) == 0) mask = 3'b111;
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0;
    ready = 3'b000;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
